result_packer: RTL

Downstream store stage for the matrix-vector multiplier. It accepts the per-row 8-bit results (y' or ReLU'd z) one byte at a time and packs them little-endian into 64-bit doublewords. Full doublewords go out as single doubleword stores; a partial tail goes out as byte stores. It tracks outstanding memory acknowledgements and pulses `done_o` once every store of the result vector R has been acknowledged.

---
 rtl/asic_pkg.sv | 23 ++
 rtl/outstanding_ctr.sv | 44 ++++
 rtl/result_packer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/asic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asic_pkg
// Description : Shared types and memory-command constants for the MVM store path.
// Revision    : 1.0 - initial release
// ============================================================================
package asic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_STORE_DW = 3'd2,
        ST_FLUSH_B  = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } packer_state_t;

    localparam logic [4:0] MEM_CMD_WR = 5'd1;
    localparam logic [2:0] MEM_TYP_B  = 3'd0;
    localparam logic [2:0] MEM_TYP_D  = 3'd3;

endpackage
`default_nettype wire

// File: rtl/outstanding_ctr.sv
`default_nettype none
// ============================================================================
// Module      : outstanding_ctr
// Description : Saturating up/down count of memory requests awaiting a response.
// Revision    : 1.0 - initial release
// ============================================================================
module outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] count_o,
    output logic       full_o,
    output logic       zero_o
);

    localparam logic [3:0] C_MAX = 4'(MAX_OUTSTANDING);

    logic [3:0] r_count;
    logic       w_dec;

    // A response with nothing in flight belongs to abandoned work; drop it.
    assign w_dec = dec_i && (r_count != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (inc_i && !w_dec) begin
            if (r_count != C_MAX) begin
                r_count <= r_count + 4'd1;
            end
        end else if (w_dec && !inc_i) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign count_o = r_count;
    assign full_o  = (r_count == C_MAX);
    assign zero_o  = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// Module      : result_packer
// Description : Packs result bytes into doubleword stores, flushes the tail as
//               byte stores and signals when every store has been acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module result_packer
    import asic_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int ADDR_W          = 40,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_data_i,
    input  logic              in_last_i,
    input  logic              mem_req_ready_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [4:0]        mem_req_cmd_o,
    output logic [2:0]        mem_req_typ_o,
    output logic [XLEN-1:0]   mem_req_data_o,
    input  logic              mem_resp_valid_i
);

    packer_state_t     r_state;
    packer_state_t     w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [3:0]        r_cnt;
    logic [2:0]        r_k;
    logic [XLEN-1:0]   r_pack;
    logic              r_last;

    logic [3:0]        w_outstanding;
    logic              w_full;
    logic              w_zero;
    logic              w_issuing;
    logic              w_fire;
    logic              w_flush_end;

    assign w_issuing   = (r_state == ST_STORE_DW) || (r_state == ST_FLUSH_B);
    assign w_fire      = w_issuing && !w_full && mem_req_ready_i;
    assign w_flush_end = (r_state == ST_FLUSH_B) && w_fire && ({1'b0, r_k} == r_cnt - 4'd1);

    outstanding_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (w_fire),
        .dec_i   (mem_resp_valid_i),
        .count_o (w_outstanding),
        .full_o  (w_full),
        .zero_o  (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        busy_o          = 1'b1;
        done_o          = 1'b0;
        in_ready_o      = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_cmd_o   = 5'd0;
        mem_req_typ_o   = 3'd0;
        mem_req_data_o  = '0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (r_cnt == 4'd7)  w_next = ST_STORE_DW;
                    else if (in_last_i) w_next = ST_FLUSH_B;
                end
            end
            ST_STORE_DW: begin
                mem_req_valid_o = !w_full;
                mem_req_addr_o  = r_ptr;
                mem_req_cmd_o   = MEM_CMD_WR;
                mem_req_typ_o   = MEM_TYP_D;
                mem_req_data_o  = r_pack;
                if (w_fire) w_next = r_last ? ST_DRAIN : ST_COLLECT;
            end
            ST_FLUSH_B: begin
                mem_req_valid_o = !w_full;
                mem_req_addr_o  = r_ptr + ADDR_W'(r_k);
                mem_req_cmd_o   = MEM_CMD_WR;
                mem_req_typ_o   = MEM_TYP_B;
                mem_req_data_o  = {{(XLEN-8){1'b0}}, r_pack[8*r_k +: 8]};
                if (w_flush_end) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_zero) w_next = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy_o = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: the pointer only advances per doubleword; tail bytes index off it with r_k.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_cnt  <= 4'd0;
            r_k    <= 3'd0;
            r_pack <= '0;
            r_last <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_ptr  <= {base_addr_i[ADDR_W-1:3], base_addr_i[2:0] & 3'b000};
                        r_cnt  <= 4'd0;
                        r_k    <= 3'd0;
                        r_pack <= '0;
                        r_last <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid_i) begin
                        r_pack[8*r_cnt[2:0] +: 8] <= in_data_i;
                        r_cnt  <= r_cnt + 4'd1;
                        r_last <= in_last_i;
                        r_k    <= 3'd0;
                    end
                end
                ST_STORE_DW: begin
                    if (w_fire) begin
                        r_ptr  <= r_ptr + ADDR_W'(8);
                        r_cnt  <= 4'd0;
                        r_pack <= '0;
                    end
                end
                ST_FLUSH_B: begin
                    if (w_fire) r_k <= r_k + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
